mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle control unit for the MIPS-subset datapath. A Moore FSM sequences fetch, decode,
//  execute, memory and write-back. It drives every datapath select and write enable, including
//  the 2-bit ALUSrcBControl of the ALU B-operand mux: 00=SE16_32, 01=const 4, 10=RegB, 11=SL2.
//  It sits beside the datapath top and is the only source of control strobes.
// PARAMETERS
//  MEM_WAIT   1   extra cycles memory needs before read data is valid (0..7)
// PORTS
//  clk            in   1  system clock, rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0]
//  zero           in   1  ALU zero flag
//  overflow       in   1  ALU overflow flag
//  PCWrite        out  1  unconditional PC load
//  PCWriteCond    out  1  PC load if zero=1
//  IorD           out  1  memory address: 0=PC, 1=ALUOut
//  MemWrite       out  1  memory write strobe
//  IRWrite        out  1  instruction register load
//  RegDst         out  1  write reg: 0=rt, 1=rd
//  MemToReg       out  1  reg write data: 0=ALUOut, 1=MDR
//  RegWrite       out  1  register file write
//  ALUSrcA        out  1  0=PC, 1=RegA
//  ALUSrcBControl out  2  B-operand select (encoding above)
//  ALUOp          out  3  001 add, 010 sub, 011 and
//  PCSource       out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=EXC_VEC constant
//  EPCWrite       out  1  EPC load (takes ALUOut)
//  state_out      out  4  current state code, debug
// BEHAVIOUR
//  - Outputs are decoded combinationally from the state register only (Moore).
//    Signals not listed for a state are 0.
//  - reset_n=0 forces state=RESET (0) and clears wait_cnt immediately. In RESET all outputs are 0.
//    Reset mid-instruction aborts it, with no partial write.
//  - Wait counter wait_cnt (3b): loads 0 on entry to FETCH or MEMRD, increments while
//    wait_cnt<MEM_WAIT, and the state advances when wait_cnt==MEM_WAIT.
//  - States and codes (name=code: outputs -> next):
//    RESET=0: none -> FETCH.
//    FETCH=1: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=001. On the final wait cycle also
//      IRWrite=1, PCWrite=1, PCSource=00 -> DECODE. Otherwise stay.
//    DECODE=2: ALUSrcA=0, ALUSrcB=11, ALUOp=001 (branch target into ALUOut).
//      Dispatch: op 00 with funct 20/22/24 -> EXEC_R; op 23/2B -> MEMADR; op 08 -> ADDI;
//      op 04 -> BEQ; op 02 -> JUMP; anything else -> EXC.
//    EXEC_R=3: ALUSrcA=1, ALUSrcB=10, ALUOp from funct (20->001, 22->010, 24->011) -> WB_R.
//    WB_R=4: RegDst=1, RegWrite=1 (suppressed if overflow=1 with funct 20/22). Goes to EXC if
//      that suppression occurred, else FETCH.
//    MEMADR=5: ALUSrcA=1, ALUSrcB=00, ALUOp=001 -> MEMRD (op 23) or MEMWR (op 2B).
//    MEMRD=6: IorD=1, waits as in FETCH -> WB_MEM.
//    WB_MEM=7: MemToReg=1, RegDst=0, RegWrite=1 -> FETCH.
//    MEMWR=8: IorD=1, MemWrite=1 for exactly one cycle -> FETCH.
//    ADDI=9: ALUSrcA=1, ALUSrcB=00, ALUOp=001 -> WB_I.
//    WB_I=10: RegDst=0, RegWrite=1 unless overflow; on overflow -> EXC, else FETCH.
//    BEQ=11: ALUSrcA=1, ALUSrcB=10, ALUOp=010, PCWriteCond=1, PCSource=01 -> FETCH.
//    JUMP=12: PCWrite=1, PCSource=10 -> FETCH.
//    EXC=13: ALUSrcA=0, ALUSrcB=01, ALUOp=010 (PC-4), EPCWrite=1, PCWrite=1,
//      PCSource=11 -> FETCH.
//  - Codes 14-15 are illegal. They decode with all outputs 0 -> RESET next cycle.
//  - opcode/funct are sampled in DECODE and later states. IR is stable because IRWrite is
//    only active in FETCH.
//  - Latency (MEM_WAIT=1): R/ADDI 5 cycles, LW 7, SW 5, BEQ 4, J 4, exception 4.
//  - MemWrite and RegWrite are never high in the same cycle. IRWrite is never high outside FETCH.
// TESTING
//  - Reset asserted mid-MEMRD -> state_out=0 asynchronously, all strobes 0. After release:
//    FETCH, then IRWrite high on cycle MEM_WAIT+1.
//  - add (op 00, funct 20), overflow=0 -> states 1,1,2,3,4. ALUSrcB=10 and ALUOp=001 in
//    state 3; RegWrite=1, RegDst=1 in state 4.
//  - lw (op 23), MEM_WAIT=2 -> FETCH 3 cycles, MEMRD 3 cycles, WB_MEM with MemToReg=1.
//    Total 9 cycles.
//  - beq (op 04): zero=1 -> PCWriteCond=1, PCSource=01; zero=0 -> same strobes, and the bench
//    confirms the PC is unchanged.
//  - addi with overflow=1 in WB_I -> RegWrite=0. Next state EXC with EPCWrite=1,
//    PCSource=11, then FETCH.
//  - Illegal opcode 3F -> DECODE, EXC, FETCH. Force state 14 -> RESET next edge, outputs 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM that sequences fetch, decode, execute,
// memory and write-back and drives every datapath select and write strobe.
module mc_control_fsm #(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcBControl,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       EPCWrite,
   output logic [3:0] state_out
);

   // state   | meaning
   // RESET   | idle after reset, all strobes low
   // FETCH   | read instruction, PC+4; IR/PC load on last wait cycle
   // DECODE  | branch target into ALUOut, dispatch on opcode/funct
   // EXEC_R  | R-type ALU operation
   // WB_R    | R-type write-back to rd (blocked on add/sub overflow)
   // MEMADR  | load/store address computation
   // MEMRD   | memory read, waits MEM_WAIT cycles
   // WB_MEM  | load data write-back to rt
   // MEMWR   | single-cycle memory write
   // ADDI    | immediate add
   // WB_I    | immediate write-back to rt (blocked on overflow)
   // BEQ     | compare, conditional PC load from ALUOut
   // JUMP    | PC load from jump target
   // EXC     | EPC <= PC-4, PC <= exception vector
   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXEC_R = 4'd3,
      ST_WB_R   = 4'd4,
      ST_MEMADR = 4'd5,
      ST_MEMRD  = 4'd6,
      ST_WB_MEM = 4'd7,
      ST_MEMWR  = 4'd8,
      ST_ADDI   = 4'd9,
      ST_WB_I   = 4'd10,
      ST_BEQ    = 4'd11,
      ST_JUMP   = 4'd12,
      ST_EXC    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   // Held as a plain vector so illegal codes 14/15 remain representable.
   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [2:0] r_wait_cnt;
   logic       w_wait_done;
   logic       w_funct_ok;
   logic       w_r_trap;
   logic       w_unused;

   assign w_wait_done = (r_wait_cnt == 3'(MEM_WAIT));
   assign w_funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
   assign w_r_trap    = overflow && ((funct == FN_ADD) || (funct == FN_SUB));
   assign w_unused    = zero;  // branch condition is resolved in the datapath
   assign state_out   = r_state;

   always_comb begin
      w_next = ST_RESET;
      case (r_state)
         ST_RESET:  w_next = ST_FETCH;
         ST_FETCH:  w_next = w_wait_done ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            if (opcode == OP_RTYPE && w_funct_ok)          w_next = ST_EXEC_R;
            else if (opcode == OP_LW || opcode == OP_SW)   w_next = ST_MEMADR;
            else if (opcode == OP_ADDI)                    w_next = ST_ADDI;
            else if (opcode == OP_BEQ)                     w_next = ST_BEQ;
            else if (opcode == OP_J)                       w_next = ST_JUMP;
            else                                           w_next = ST_EXC;
         end
         ST_EXEC_R: w_next = ST_WB_R;
         ST_WB_R:   w_next = w_r_trap ? ST_EXC : ST_FETCH;
         ST_MEMADR: w_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  w_next = w_wait_done ? ST_WB_MEM : ST_MEMRD;
         ST_WB_MEM: w_next = ST_FETCH;
         ST_MEMWR:  w_next = ST_FETCH;
         ST_ADDI:   w_next = ST_WB_I;
         ST_WB_I:   w_next = overflow ? ST_EXC : ST_FETCH;
         ST_BEQ:    w_next = ST_FETCH;
         ST_JUMP:   w_next = ST_FETCH;
         ST_EXC:    w_next = ST_FETCH;
         default:   w_next = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RESET;
         r_wait_cnt <= 3'd0;
      end else begin
         r_state <= w_next;
         if ((w_next == ST_FETCH || w_next == ST_MEMRD) && (w_next != r_state))
            r_wait_cnt <= 3'd0;
         else if ((r_state == ST_FETCH || r_state == ST_MEMRD) && !w_wait_done)
            r_wait_cnt <= r_wait_cnt + 3'd1;
      end
   end

   always_comb begin
      PCWrite        = 1'b0;
      PCWriteCond    = 1'b0;
      IorD           = 1'b0;
      MemWrite       = 1'b0;
      IRWrite        = 1'b0;
      RegDst         = 1'b0;
      MemToReg       = 1'b0;
      RegWrite       = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcBControl = 2'b00;
      ALUOp          = 3'b000;
      PCSource       = 2'b00;
      EPCWrite       = 1'b0;
      case (r_state)
         ST_FETCH: begin
            ALUSrcBControl = 2'b01;
            ALUOp          = 3'b001;
            IRWrite        = w_wait_done;
            PCWrite        = w_wait_done;
         end
         ST_DECODE: begin
            ALUSrcBControl = 2'b11;
            ALUOp          = 3'b001;
         end
         ST_EXEC_R: begin
            ALUSrcA        = 1'b1;
            ALUSrcBControl = 2'b10;
            if (funct == FN_SUB)      ALUOp = 3'b010;
            else if (funct == FN_AND) ALUOp = 3'b011;
            else                      ALUOp = 3'b001;
         end
         ST_WB_R: begin
            RegDst   = 1'b1;
            RegWrite = !w_r_trap;
         end
         ST_MEMADR, ST_ADDI: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b001;
         end
         ST_MEMRD:  IorD = 1'b1;
         ST_WB_MEM: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         ST_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         ST_WB_I:   RegWrite = !overflow;
         ST_BEQ: begin
            ALUSrcA        = 1'b1;
            ALUSrcBControl = 2'b10;
            ALUOp          = 3'b010;
            PCWriteCond    = 1'b1;
            PCSource       = 2'b01;
         end
         ST_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         ST_EXC: begin
            ALUSrcBControl = 2'b01;
            ALUOp          = 3'b010;
            EPCWrite       = 1'b1;
            PCWrite        = 1'b1;
            PCSource       = 2'b11;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected state/strobe sequences are queued
// when the instruction is driven and compared cycle by cycle as the FSM steps.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset_n, reset_n2;
   logic [5:0] opcode, funct;
   logic       zero, overflow;

   logic       pcw_a, pcwc_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, asa_a, epc_a;
   logic [1:0] asb_a, pcs_a;
   logic [2:0] aop_a;
   logic [3:0] state_a;
   logic       pcw_b, pcwc_b, iord_b, mw_b, irw_b, rd_b, m2r_b, rw_b, asa_b, epc_b;
   logic [1:0] asb_b, pcs_b;
   logic [2:0] aop_b;
   logic [3:0] state_b;
   logic [16:0] vec_a, vec_b;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [3:0]  st;
      logic [16:0] vec;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_WAIT(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
      .zero(zero), .overflow(overflow),
      .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemWrite(mw_a),
      .IRWrite(irw_a), .RegDst(rd_a), .MemToReg(m2r_a), .RegWrite(rw_a),
      .ALUSrcA(asa_a), .ALUSrcBControl(asb_a), .ALUOp(aop_a), .PCSource(pcs_a),
      .EPCWrite(epc_a), .state_out(state_a)
   );

   mc_control_fsm #(.MEM_WAIT(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n2), .opcode(opcode), .funct(funct),
      .zero(zero), .overflow(overflow),
      .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemWrite(mw_b),
      .IRWrite(irw_b), .RegDst(rd_b), .MemToReg(m2r_b), .RegWrite(rw_b),
      .ALUSrcA(asa_b), .ALUSrcBControl(asb_b), .ALUOp(aop_b), .PCSource(pcs_b),
      .EPCWrite(epc_b), .state_out(state_b)
   );

   assign vec_a = {pcw_a, pcwc_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, asa_a,
                   asb_a, aop_a, pcs_a, epc_a};
   assign vec_b = {pcw_b, pcwc_b, iord_b, mw_b, irw_b, rd_b, m2r_b, rw_b, asa_b,
                   asb_b, aop_b, pcs_b, epc_b};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected strobe vector for one state, straight from the state/output table.
   function automatic logic [16:0] exp_vec(input logic [3:0] st, input bit last,
                                           input logic [5:0] fn, input bit ov);
      logic pcw = 0, pcwc = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0;
      logic asa = 0, epc = 0;
      logic [1:0] asb = 2'b00, pcs = 2'b00;
      logic [2:0] aop = 3'b000;
      case (st)
         4'd1:  begin asb = 2'b01; aop = 3'b001; irw = last; pcw = last; end
         4'd2:  begin asb = 2'b11; aop = 3'b001; end
         4'd3:  begin
            asa = 1; asb = 2'b10;
            aop = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
         end
         4'd4:  begin rd = 1; rw = !(ov && (fn == 6'h20 || fn == 6'h22)); end
         4'd5:  begin asa = 1; aop = 3'b001; end
         4'd6:  iord = 1;
         4'd7:  begin m2r = 1; rw = 1; end
         4'd8:  begin iord = 1; mw = 1; end
         4'd9:  begin asa = 1; aop = 3'b001; end
         4'd10: rw = !ov;
         4'd11: begin asa = 1; asb = 2'b10; aop = 3'b010; pcwc = 1; pcs = 2'b01; end
         4'd12: begin pcw = 1; pcs = 2'b10; end
         4'd13: begin asb = 2'b01; aop = 3'b010; epc = 1; pcw = 1; pcs = 2'b11; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, epc};
   endfunction

   task automatic push_exp(input logic [3:0] st, input bit last,
                           input logic [5:0] fn, input bit ov);
      exp_t e;
      e.st  = st;
      e.vec = exp_vec(st, last, fn, ov);
      sb.push_back(e);
   endtask

   // Entered with the FSM about to step into FETCH on the next rising edge.
   task automatic run_instr(input bit sel, input string name, input logic [5:0] op,
                            input logic [5:0] fn, input bit z, input bit ov, input int mw);
      exp_t        e;
      logic [3:0]  st;
      logic [16:0] v;
      int          k = 0;
      sb.delete();
      for (int i = 0; i <= mw; i++) push_exp(4'd1, (i == mw), fn, ov);
      push_exp(4'd2, 0, fn, ov);
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
         push_exp(4'd3, 0, fn, ov);
         push_exp(4'd4, 0, fn, ov);
         if (ov && (fn == 6'h20 || fn == 6'h22)) push_exp(4'd13, 0, fn, ov);
      end else if (op == 6'h23) begin
         push_exp(4'd5, 0, fn, ov);
         for (int i = 0; i <= mw; i++) push_exp(4'd6, 0, fn, ov);
         push_exp(4'd7, 0, fn, ov);
      end else if (op == 6'h2B) begin
         push_exp(4'd5, 0, fn, ov);
         push_exp(4'd8, 0, fn, ov);
      end else if (op == 6'h08) begin
         push_exp(4'd9, 0, fn, ov);
         push_exp(4'd10, 0, fn, ov);
         if (ov) push_exp(4'd13, 0, fn, ov);
      end else if (op == 6'h04) begin
         push_exp(4'd11, 0, fn, ov);
      end else if (op == 6'h02) begin
         push_exp(4'd12, 0, fn, ov);
      end else begin
         push_exp(4'd13, 0, fn, ov);
      end
      while (sb.size() > 0) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            opcode = op; funct = fn; zero = z; overflow = ov;
            #1;
         end
         e  = sb.pop_front();
         st = sel ? state_b : state_a;
         v  = sel ? vec_b : vec_a;
         chk($sformatf("%s_c%0d_state", name, k), 32'(st), 32'(e.st));
         chk($sformatf("%s_c%0d_strobes", name, k), 32'(v), 32'(e.vec));
         if (e.st == 4'd11)
            chk($sformatf("%s_pc_load", name), 32'(v[16] | (v[15] & z)), 32'(z));
         if (v[13] && v[9]) chk($sformatf("%s_c%0d_mw_rw", name, k), 32'd1, 32'd0);
         k++;
      end
   endtask

   initial begin
      bit found;
      reset_n = 1'b1; reset_n2 = 1'b1;
      opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
      #3;
      reset_n = 1'b0; reset_n2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state_a), 32'd0);
      chk("reset_strobes", 32'(vec_a), 32'd0);
      chk("reset_state_mw2", 32'(state_b), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_instr(0, "add",       6'h00, 6'h20, 0, 0, 1);
      run_instr(0, "sub",       6'h00, 6'h22, 0, 0, 1);
      run_instr(0, "and_ovf",   6'h00, 6'h24, 0, 1, 1);
      run_instr(0, "add_ovf",   6'h00, 6'h20, 0, 1, 1);
      run_instr(0, "sub_ovf",   6'h00, 6'h22, 0, 1, 1);
      run_instr(0, "sw",        6'h2B, 6'h00, 0, 0, 1);
      run_instr(0, "lw",        6'h23, 6'h00, 0, 0, 1);
      run_instr(0, "beq_taken", 6'h04, 6'h00, 1, 0, 1);
      run_instr(0, "beq_not",   6'h04, 6'h00, 0, 0, 1);
      run_instr(0, "jump",      6'h02, 6'h00, 0, 0, 1);
      run_instr(0, "addi",      6'h08, 6'h00, 0, 0, 1);
      run_instr(0, "addi_ovf",  6'h08, 6'h00, 0, 1, 1);
      run_instr(0, "illegal",   6'h3F, 6'h00, 0, 0, 1);
      run_instr(0, "bad_funct", 6'h00, 6'h25, 0, 0, 1);

      // Reset in the middle of a load read phase.
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin opcode = 6'h23; funct = 6'h00; zero = 0; overflow = 0; end
         if (state_a == 4'd6) found = 1;
      end
      chk("memrd_reached", 32'(state_a), 32'd6);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrd_reset_state", 32'(state_a), 32'd0);
      chk("midrd_reset_strobes", 32'(vec_a), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_instr(0, "post_reset_add", 6'h00, 6'h20, 0, 0, 1);

      // Illegal state code falls back to RESET.
      @(negedge clk);
      force u_dut.r_state = 4'd14;
      #1;
      chk("illegal14_state", 32'(state_a), 32'd14);
      chk("illegal14_strobes", 32'(vec_a), 32'd0);
      release u_dut.r_state;
      @(posedge clk);
      #1;
      chk("illegal14_next", 32'(state_a), 32'd0);
      chk("illegal14_next_strobes", 32'(vec_a), 32'd0);
      run_instr(0, "post_illegal_sub", 6'h00, 6'h22, 0, 0, 1);
      @(posedge clk);
      #1;
      chk("sub_to_fetch", 32'(state_a), 32'd1);

      // Longer memory wait on the second instance.
      @(negedge clk);
      reset_n  = 1'b0;
      reset_n2 = 1'b1;
      run_instr(1, "lw_mw2", 6'h23, 6'h00, 0, 0, 2);
      @(posedge clk);
      #1;
      chk("lw_mw2_to_fetch", 32'(state_b), 32'd1);
      chk("held_in_reset", 32'(state_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
